// File: rtl/enc_32_to_1_if.sv
// Bus bundle for the 32-way registered word selector: 32 candidate words,
// the 5-bit select index and the registered selected word.
interface enc_32_to_1_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] mux_input_0,  mux_input_1,  mux_input_2,  mux_input_3;
    logic [DATA_WIDTH-1:0] mux_input_4,  mux_input_5,  mux_input_6,  mux_input_7;
    logic [DATA_WIDTH-1:0] mux_input_8,  mux_input_9,  mux_input_10, mux_input_11;
    logic [DATA_WIDTH-1:0] mux_input_12, mux_input_13, mux_input_14, mux_input_15;
    logic [DATA_WIDTH-1:0] mux_input_16, mux_input_17, mux_input_18, mux_input_19;
    logic [DATA_WIDTH-1:0] mux_input_20, mux_input_21, mux_input_22, mux_input_23;
    logic [DATA_WIDTH-1:0] mux_input_24, mux_input_25, mux_input_26, mux_input_27;
    logic [DATA_WIDTH-1:0] mux_input_28, mux_input_29, mux_input_30, mux_input_31;
    logic [4:0]            mux_sel;
    logic [DATA_WIDTH-1:0] mux_out;

    modport master (
        output mux_input_0,  mux_input_1,  mux_input_2,  mux_input_3,
               mux_input_4,  mux_input_5,  mux_input_6,  mux_input_7,
               mux_input_8,  mux_input_9,  mux_input_10, mux_input_11,
               mux_input_12, mux_input_13, mux_input_14, mux_input_15,
               mux_input_16, mux_input_17, mux_input_18, mux_input_19,
               mux_input_20, mux_input_21, mux_input_22, mux_input_23,
               mux_input_24, mux_input_25, mux_input_26, mux_input_27,
               mux_input_28, mux_input_29, mux_input_30, mux_input_31,
               mux_sel,
        input  mux_out
    );

    modport slave (
        input  mux_input_0,  mux_input_1,  mux_input_2,  mux_input_3,
               mux_input_4,  mux_input_5,  mux_input_6,  mux_input_7,
               mux_input_8,  mux_input_9,  mux_input_10, mux_input_11,
               mux_input_12, mux_input_13, mux_input_14, mux_input_15,
               mux_input_16, mux_input_17, mux_input_18, mux_input_19,
               mux_input_20, mux_input_21, mux_input_22, mux_input_23,
               mux_input_24, mux_input_25, mux_input_26, mux_input_27,
               mux_input_28, mux_input_29, mux_input_30, mux_input_31,
               mux_sel,
        output mux_out
    );
endinterface

// File: rtl/enc_32_to_1.sv
// Registered 32-way word selector: MiniSRC bus source mux, selected word
// appears on mux_out one clock after it is presented.
module enc_32_to_1 #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         clr,
    enc_32_to_1_if.slave bus
);
    logic [DATA_WIDTH-1:0] sel_word;

    always_comb begin
        sel_word = '0;
        case (bus.mux_sel)
            5'd0:  sel_word = bus.mux_input_0;
            5'd1:  sel_word = bus.mux_input_1;
            5'd2:  sel_word = bus.mux_input_2;
            5'd3:  sel_word = bus.mux_input_3;
            5'd4:  sel_word = bus.mux_input_4;
            5'd5:  sel_word = bus.mux_input_5;
            5'd6:  sel_word = bus.mux_input_6;
            5'd7:  sel_word = bus.mux_input_7;
            5'd8:  sel_word = bus.mux_input_8;
            5'd9:  sel_word = bus.mux_input_9;
            5'd10: sel_word = bus.mux_input_10;
            5'd11: sel_word = bus.mux_input_11;
            5'd12: sel_word = bus.mux_input_12;
            5'd13: sel_word = bus.mux_input_13;
            5'd14: sel_word = bus.mux_input_14;
            5'd15: sel_word = bus.mux_input_15;
            5'd16: sel_word = bus.mux_input_16;
            5'd17: sel_word = bus.mux_input_17;
            5'd18: sel_word = bus.mux_input_18;
            5'd19: sel_word = bus.mux_input_19;
            5'd20: sel_word = bus.mux_input_20;
            5'd21: sel_word = bus.mux_input_21;
            5'd22: sel_word = bus.mux_input_22;
            5'd23: sel_word = bus.mux_input_23;
            5'd24: sel_word = bus.mux_input_24;
            5'd25: sel_word = bus.mux_input_25;
            5'd26: sel_word = bus.mux_input_26;
            5'd27: sel_word = bus.mux_input_27;
            5'd28: sel_word = bus.mux_input_28;
            5'd29: sel_word = bus.mux_input_29;
            5'd30: sel_word = bus.mux_input_30;
            5'd31: sel_word = bus.mux_input_31;
            // Only reachable with an X/Z select; forces a clean zero
            default: sel_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus.mux_out <= '0;
        end else begin
            bus.mux_out <= sel_word;
        end
    end
endmodule

// File: tb/tb_enc_32_to_1.sv
// Self-checking bench for enc_32_to_1: directed table sweep, hand-written
// reset/latency/isolation sequences, and randomized traffic against a model.
module tb_enc_32_to_1;
    logic        clk;
    logic        clr;
    logic [31:0] words [32];
    int          checks;
    int          errors;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [32];

    enc_32_to_1_if #(.DATA_WIDTH(32)) bus ();

    enc_32_to_1 #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    assign bus.mux_input_0  = words[0];  assign bus.mux_input_1  = words[1];
    assign bus.mux_input_2  = words[2];  assign bus.mux_input_3  = words[3];
    assign bus.mux_input_4  = words[4];  assign bus.mux_input_5  = words[5];
    assign bus.mux_input_6  = words[6];  assign bus.mux_input_7  = words[7];
    assign bus.mux_input_8  = words[8];  assign bus.mux_input_9  = words[9];
    assign bus.mux_input_10 = words[10]; assign bus.mux_input_11 = words[11];
    assign bus.mux_input_12 = words[12]; assign bus.mux_input_13 = words[13];
    assign bus.mux_input_14 = words[14]; assign bus.mux_input_15 = words[15];
    assign bus.mux_input_16 = words[16]; assign bus.mux_input_17 = words[17];
    assign bus.mux_input_18 = words[18]; assign bus.mux_input_19 = words[19];
    assign bus.mux_input_20 = words[20]; assign bus.mux_input_21 = words[21];
    assign bus.mux_input_22 = words[22]; assign bus.mux_input_23 = words[23];
    assign bus.mux_input_24 = words[24]; assign bus.mux_input_25 = words[25];
    assign bus.mux_input_26 = words[26]; assign bus.mux_input_27 = words[27];
    assign bus.mux_input_28 = words[28]; assign bus.mux_input_29 = words[29];
    assign bus.mux_input_30 = words[30]; assign bus.mux_input_31 = words[31];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        for (int k = 0; k < 32; k++) words[k] = 32'(2 * (k + 1));
    endtask

    initial begin
        logic [31:0] exp_q;
        logic        clr_r;
        logic [4:0]  sel_r;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) begin
            vecs[i].sel = 5'(i);
            vecs[i].exp = 32'(2 * (i + 1));
        end

        // Reset: asynchronous clear, hold, release
        clr = 1'b1;
        load_default();
        bus.mux_sel = 5'd5;
        #2;
        check("reset_state", bus.mux_out, 32'd0);
        step();
        check("reset_hold", bus.mux_out, 32'd0);
        clr = 1'b0;
        step();
        check("first_capture", bus.mux_out, 32'd12);
        #3;
        clr = 1'b1;
        #1;
        check("async_clear", bus.mux_out, 32'd0);
        step();
        check("clear_held", bus.mux_out, 32'd0);
        clr = 1'b0;
        step();
        check("capture_after_release", bus.mux_out, 32'd12);

        // Full sweep from the table
        for (int i = 0; i < 32; i++) begin
            bus.mux_sel = vecs[i].sel;
            step();
            check($sformatf("sweep_sel%0d", i), bus.mux_out, vecs[i].exp);
        end

        // Latency: output holds until the next edge
        bus.mux_sel = 5'd3;
        step();
        check("lat_sel3", bus.mux_out, 32'd8);
        bus.mux_sel = 5'd4;
        #3;
        check("lat_hold", bus.mux_out, 32'd8);
        step();
        check("lat_sel4", bus.mux_out, 32'd10);

        // Non-selected isolation
        bus.mux_sel = 5'd7;
        step();
        check("iso_sel7", bus.mux_out, 32'd16);
        words[8] = 32'hDEADBEEF;
        step();
        check("iso_other_change", bus.mux_out, 32'd16);
        words[7] = 32'hFFFFFFFF;
        step();
        check("iso_selected_change", bus.mux_out, 32'hFFFFFFFF);

        // Full-width boundary values
        words[0]  = 32'h80000001;
        words[31] = 32'h7FFFFFFE;
        bus.mux_sel = 5'd0;
        step();
        check("width_sel0", bus.mux_out, 32'h80000001);
        bus.mux_sel = 5'd31;
        step();
        check("width_sel31", bus.mux_out, 32'h7FFFFFFE);

        // Simultaneous select and data change
        load_default();
        step();
        check("simul_pre", bus.mux_out, 32'd64);
        bus.mux_sel = 5'd0;
        words[0] = 32'd100;
        step();
        check("simul_post", bus.mux_out, 32'd100);

        // Randomized traffic: expected value is the word at the chosen index,
        // or zero when clear is active during the cycle
        for (int n = 0; n < 300; n++) begin
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(1) == 1) words[$urandom_range(31)] = $urandom;
            end
            sel_r = 5'($urandom_range(31));
            clr_r = ($urandom_range(19) == 0);
            bus.mux_sel = sel_r;
            clr = clr_r;
            exp_q = clr_r ? 32'd0 : words[sel_r];
            step();
            check("random", bus.mux_out, exp_q);
            clr = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
